led_panel_receiver: RTL and testbench
=====================================

# led_panel_receiver

Panel-side receiver for the LED display serial interface: captures the bit clock, RGB top/bottom data, row address, latch enable and output enable that the display driver emits, and rebuilds complete rows in the system clock domain. Each latched row is presented on a valid/ready write port, together with its row address and a measured lit time, for a frame buffer or checker. It is synthesisable and serves both as the loopback checker on the board and as the reference display model in simulation.

## Interface
- NUM_COLS, 64, pixels per row, which is the number of bit clocks per row.
- ADDR_W, 4, row address width; NUM_ROWS/2 addressable row pairs.
- CNT_W, 16, width of the lit-time counter.
- clk_in  in  1  system clock, 100 MHz.
- n_reset_in  in  1  reset; one clock; reset is synchronous and active-low.
- bclk_in  in  1  asynchronous bit clock from the driver.
- rgb_top_in  in  3  top-half R,G,B serial data.
- rgb_bot_in  in  3  bottom-half R,G,B serial data.
- addr_in  in  ADDR_W  row address.
- le_in  in  1  latch enable, active high.
- oe_in  in  1  output enable, active low.
- row_valid_out  out  1  a latched row is available.
- row_ready_in  in  1  consumer accepts the row.
- row_addr_out  out  ADDR_W  address sampled at the latch edge.
- row_top_out  out  3×NUM_COLS  top-half colour planes, as [2:0][NUM_COLS-1:0].
- row_bot_out  out  3×NUM_COLS  bottom-half colour planes.
- row_bits_out  out  $clog2(NUM_COLS+1)  bit clocks counted for this row.
- lit_count_out  out  CNT_W  clk_in cycles with oe_in low during the previous latch period.
- err_overflow_out  out  1  sticky: a row was dropped.
- err_length_out  out  1  sticky: a row was latched with bit count ≠ NUM_COLS.

## Operation
- All panel inputs pass through one 2-flop synchronizer of identical depth, so data stays aligned with bclk. Edges are detected from stage 2 against a registered copy.
- **bclk rising edge:** shift the top and bottom registers per colour plane as reg <= {reg[NUM_COLS-2:0], bit}. The first bit shifted in ends at index NUM_COLS-1. The bit counter increments and saturates at NUM_COLS+1.
- **lit counter:** increments every cycle the synced oe is low, saturating at 2^CNT_W−1.
- **le rising edge:**
  - Copy the shift registers, synced addr, bit count and lit count to the output holding registers.
  - Set row_valid_out.
  - Clear the bit counter and lit counter. The shift registers are not cleared.
  - Set err_length_out if the bit count ≠ NUM_COLS.
- **Handshake:** the transfer completes on a cycle where row_valid_out && row_ready_in, which clears row_valid_out. Outputs hold stable while valid && !ready.
- **Latch while still valid and not accepted:**
  - The new row overwrites the holding registers.
  - row_valid_out stays high.
  - err_overflow_out is set.
  - If row_ready_in is high in that same cycle, the old row counts as accepted, the new row becomes valid, and no error is flagged.
- **bclk and le edges in the same cycle:** the shift applies first, so the latched row includes that bit and the count includes it. The counter then restarts at 0.
- **Reset:** all outputs, counters, shift registers and synchronizer flops go to 0. Error flags clear only on reset. Reset mid-row discards the partial row.
- A row with no bit clocks still latches, with row_bits_out = 0 and err_length_out set.
- Each simultaneous oe/le edge is handled independently. The lit cycle on the latch edge is counted into the closing period.

## Timing
- Input constraint: bclk high and low phases are each ≥ 2 clk_in periods. A 21 MHz bclk against a 100 MHz clk_in meets this.
- Data must be stable on the clk_in edge that samples bclk rising.
- Shift latency: the register updates on the 3rd clk_in edge after bclk is first sampled high (2 sync stages + edge).
- Row latency: row_valid_out rises on the 3rd clk_in edge after le_in is first sampled high.
- Throughput: one row per latch. The consumer may hold ready high permanently.
- Error flags assert in the same cycle as the offending latch transfer.

## Structure
- Shared package led_display_pkg provides:
  - NUM_COLS and ADDR_W defaults, matching the driver.
  - typedef rgb_row_t, as logic [2:0][NUM_COLS-1:0].
  - Sync depth constant SYNC_STAGES = 2.
- Sub-module sync_2ff, parameterised by width, synchronizes bclk, le, oe, rgb_top, rgb_bot and addr as one bus.
- Edge detection, shift registers, counters and the output handshake live in the top module. Estimated 200–300 lines.

## Test plan
- **Full row:** drive 64 bclks with rgb_top = bit i of 64'h1122334455667788 (MSB first), rgb_bot inverted, addr = 4'h5, then LE. Required: row_top_out[0] == 64'h1122334455667788, row_bot_out inverted, row_addr_out = 5, row_bits_out = 64, no errors.
- **Short row:** 60 bclks then LE. Required: row_bits_out = 60, err_length_out = 1.
- **Back-pressure:** row_ready_in = 0, latch two rows. Required: second row's data visible, row_valid_out held, err_overflow_out = 1. Repeat with ready asserted on the second latch cycle; required: no error.
- **Lit time:** hold oe_in low for 500 clk_in cycles between latches. Required: lit_count_out = 500 on the next row.
- **Simultaneous edges:** bclk 64 and LE rising in the same clk_in cycle. Required: 64 bits captured, counter restarts at 0.
- **Mid-row reset:** assert n_reset_in for 1 cycle after 30 bclks, then send a full 64-bit row. Required: all outputs 0 during reset, then a clean capture with no errors.

Source files
------------

// File: rtl/led_display_pkg.sv
// led_display_pkg: shared constants and row type for the LED display serial link
package led_display_pkg;
    localparam int NUM_COLS    = 64;
    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;
    typedef logic [2:0][NUM_COLS-1:0] rgb_row_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: multi-bit flop-chain synchronizer, all bits delayed by the same depth
module sync_2ff
    import led_display_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_in,
    input  logic         n_reset_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);
    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    // Push the bus one stage deeper each clock
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    // Stage registers, cleared by reset
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) sync_q <= '0;
        else             sync_q <= sync_d;
    end
    assign q_out = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/led_panel_receiver.sv
// led_panel_receiver: rebuilds latched LED rows from the serial link and offers them on a valid/ready port
module led_panel_receiver
    import led_display_pkg::*;
#(
    parameter int NUM_COLS = led_display_pkg::NUM_COLS,
    parameter int ADDR_W   = led_display_pkg::ADDR_W,
    parameter int CNT_W    = 16
) (
    input  logic                            clk_in,
    input  logic                            n_reset_in,
    input  logic                            bclk_in,
    input  logic [2:0]                      rgb_top_in,
    input  logic [2:0]                      rgb_bot_in,
    input  logic [ADDR_W-1:0]               addr_in,
    input  logic                            le_in,
    input  logic                            oe_in,
    output logic                            row_valid_out,
    input  logic                            row_ready_in,
    output logic [ADDR_W-1:0]               row_addr_out,
    output logic [2:0][NUM_COLS-1:0]        row_top_out,
    output logic [2:0][NUM_COLS-1:0]        row_bot_out,
    output logic [$clog2(NUM_COLS+1)-1:0]   row_bits_out,
    output logic [CNT_W-1:0]                lit_count_out,
    output logic                            err_overflow_out,
    output logic                            err_length_out
);
    localparam int BW = $clog2(NUM_COLS + 1);
    localparam int SW = 9 + ADDR_W;
    localparam logic [BW-1:0] BITS_MAX  = BW'(NUM_COLS + 1);
    localparam logic [BW-1:0] BITS_FULL = BW'(NUM_COLS);

    logic [SW-1:0]            sync_out;
    logic                     bclk_s, le_s, oe_s;
    logic [2:0]               top_s, bot_s;
    logic [ADDR_W-1:0]        addr_s;
    logic                     bclk_rise, le_rise;
    logic [BW-1:0]            bits_inc;
    logic [CNT_W-1:0]         lit_inc;

    logic                     bclk_prev_q, bclk_prev_d, le_prev_q, le_prev_d;
    logic [2:0][NUM_COLS-1:0] top_sr_q, top_sr_d, bot_sr_q, bot_sr_d;
    logic [2:0][NUM_COLS-1:0] top_out_q, top_out_d, bot_out_q, bot_out_d;
    logic [BW-1:0]            bits_q, bits_d, bits_out_q, bits_out_d;
    logic [CNT_W-1:0]         lit_q, lit_d, lit_out_q, lit_out_d;
    logic [ADDR_W-1:0]        addr_out_q, addr_out_d;
    logic                     valid_q, valid_d, ovf_q, ovf_d, len_q, len_d;

    // Every panel input goes through the same synchronizer so data stays aligned with bclk
    sync_2ff #(.W(SW)) u_sync (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .d_in       ({bclk_in, le_in, oe_in, rgb_top_in, rgb_bot_in, addr_in}),
        .q_out      (sync_out)
    );
    assign {bclk_s, le_s, oe_s, top_s, bot_s, addr_s} = sync_out;

    // Edge detect, shift, count, then latch; a same-cycle bclk edge is shifted in before the latch
    always_comb begin
        bclk_rise   = bclk_s & ~bclk_prev_q;
        le_rise     = le_s & ~le_prev_q;
        bclk_prev_d = bclk_s;
        le_prev_d   = le_s;
        for (int c = 0; c < 3; c++) begin
            top_sr_d[c] = bclk_rise ? {top_sr_q[c][NUM_COLS-2:0], top_s[c]} : top_sr_q[c];
            bot_sr_d[c] = bclk_rise ? {bot_sr_q[c][NUM_COLS-2:0], bot_s[c]} : bot_sr_q[c];
        end
        bits_inc   = (bclk_rise && bits_q != BITS_MAX) ? bits_q + 1'b1 : bits_q;
        lit_inc    = (!oe_s && lit_q != '1) ? lit_q + 1'b1 : lit_q;
        bits_d     = le_rise ? '0 : bits_inc;
        lit_d      = le_rise ? '0 : lit_inc;
        top_out_d  = le_rise ? top_sr_d : top_out_q;
        bot_out_d  = le_rise ? bot_sr_d : bot_out_q;
        addr_out_d = le_rise ? addr_s : addr_out_q;
        bits_out_d = le_rise ? bits_inc : bits_out_q;
        lit_out_d  = le_rise ? lit_inc : lit_out_q;
        valid_d    = le_rise | (valid_q & ~row_ready_in);
        ovf_d      = ovf_q | (le_rise & valid_q & ~row_ready_in);
        len_d      = len_q | (le_rise & (bits_inc != BITS_FULL));
    end

    // State and holding registers, all cleared by reset
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            bclk_prev_q <= 1'b0;
            le_prev_q   <= 1'b0;
            top_sr_q    <= '0;
            bot_sr_q    <= '0;
            bits_q      <= '0;
            lit_q       <= '0;
            top_out_q   <= '0;
            bot_out_q   <= '0;
            addr_out_q  <= '0;
            bits_out_q  <= '0;
            lit_out_q   <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            len_q       <= 1'b0;
        end else begin
            bclk_prev_q <= bclk_prev_d;
            le_prev_q   <= le_prev_d;
            top_sr_q    <= top_sr_d;
            bot_sr_q    <= bot_sr_d;
            bits_q      <= bits_d;
            lit_q       <= lit_d;
            top_out_q   <= top_out_d;
            bot_out_q   <= bot_out_d;
            addr_out_q  <= addr_out_d;
            bits_out_q  <= bits_out_d;
            lit_out_q   <= lit_out_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            len_q       <= len_d;
        end
    end

    assign row_valid_out    = valid_q;
    assign row_addr_out     = addr_out_q;
    assign row_top_out      = top_out_q;
    assign row_bot_out      = bot_out_q;
    assign row_bits_out     = bits_out_q;
    assign lit_count_out    = lit_out_q;
    assign err_overflow_out = ovf_q;
    assign err_length_out   = len_q;
endmodule

// File: tb/tb_led_panel_receiver.sv
// tb_led_panel_receiver: directed and randomized rows checked against a behavioural display model
module tb_led_panel_receiver;
    localparam int NC = 64;
    localparam int AW = 4;
    localparam int CW = 16;
    localparam int BW = 7;
    localparam logic [63:0] P = 64'h1122334455667788;

    logic clk = 1'b0;
    logic n_reset = 1'b0, bclk = 1'b0, le = 1'b0, oe = 1'b1, ready = 1'b0;
    logic [2:0] rt = '0, rb = '0;
    logic [AW-1:0] addr = '0;
    logic row_valid, err_ovf, err_len;
    logic [AW-1:0] row_addr;
    logic [2:0][NC-1:0] row_top, row_bot;
    logic [BW-1:0] row_bits;
    logic [CW-1:0] lit_count;

    int n_checks = 0, n_errors = 0, cyc = 0;

    always #5 clk = ~clk;

    led_panel_receiver #(.NUM_COLS(NC), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_in           (clk),
        .n_reset_in       (n_reset),
        .bclk_in          (bclk),
        .rgb_top_in       (rt),
        .rgb_bot_in       (rb),
        .addr_in          (addr),
        .le_in            (le),
        .oe_in            (oe),
        .row_valid_out    (row_valid),
        .row_ready_in     (ready),
        .row_addr_out     (row_addr),
        .row_top_out      (row_top),
        .row_bot_out      (row_bot),
        .row_bits_out     (row_bits),
        .lit_count_out    (lit_count),
        .err_overflow_out (err_ovf),
        .err_length_out   (err_len)
    );

    task automatic cmp(string name, logic [191:0] act, logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: inputs take effect two clocks after sampling; rows hold the last NC bits ever shifted
    typedef struct packed {
        logic bclk, le, oe;
        logic [2:0] t, b;
        logic [AW-1:0] a;
    } smp_t;
    smp_t cur, d1, d2, pr;
    logic [2:0] qt[$], qb[$];
    int cnt, lit, m_bits, m_lit;
    logic m_valid, m_ovf, m_len;
    logic [AW-1:0] m_addr;
    logic [2:0][NC-1:0] m_top, m_bot;

    always @(posedge clk) begin
        cur = {bclk, le, oe, rt, rb, addr};
        if (!n_reset) begin
            d1 = '0; d2 = '0; pr = '0;
            qt.delete(); qb.delete();
            cnt = 0; lit = 0; m_bits = 0; m_lit = 0;
            m_valid = 0; m_ovf = 0; m_len = 0; m_addr = '0; m_top = '0; m_bot = '0;
        end else begin
            if (m_valid && ready) m_valid = 0;
            if (d2.bclk && !pr.bclk) begin
                qt.push_back(d2.t);
                qb.push_back(d2.b);
                if (qt.size() > NC) begin
                    void'(qt.pop_front());
                    void'(qb.pop_front());
                end
                if (cnt < NC + 1) cnt++;
            end
            if (!d2.oe && lit < 65535) lit++;
            if (d2.le && !pr.le) begin
                if (m_valid) m_ovf = 1;
                if (cnt != NC) m_len = 1;
                m_valid = 1;
                m_addr = d2.a;
                m_bits = cnt;
                m_lit = lit;
                for (int c = 0; c < 3; c++)
                    for (int i = 0; i < NC; i++) begin
                        m_top[c][i] = (qt.size() - 1 - i >= 0) ? qt[qt.size()-1-i][c] : 1'b0;
                        m_bot[c][i] = (qb.size() - 1 - i >= 0) ? qb[qb.size()-1-i][c] : 1'b0;
                    end
                cnt = 0;
                lit = 0;
            end
            pr = d2; d2 = d1; d1 = cur;
        end
        #1;
        cmp("valid", row_valid, m_valid);
        cmp("addr", row_addr, m_addr);
        cmp("top", row_top, m_top);
        cmp("bot", row_bot, m_bot);
        cmp("bits", row_bits, m_bits);
        cmp("lit", lit_count, m_lit);
        cmp("ovf", err_ovf, m_ovf);
        cmp("len", err_len, m_len);
        cyc++;
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_row(logic [63:0] pat, int n, logic [AW-1:0] a);
        addr = a;
        for (int i = 0; i < n; i++) begin
            rt = {3{pat[63-i]}};
            rb = ~{3{pat[63-i]}};
            bclk = 1'b1;
            step(2);
            bclk = 1'b0;
            step(2);
        end
    endtask

    task automatic latch();
        le = 1'b1;
        step(2);
        le = 1'b0;
        step(2);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!row_valid && k < 10) begin
            step(1);
            k++;
        end
        cmp("valid_wait", row_valid, 1'b1);
    endtask

    task automatic accept();
        ready = 1'b1;
        step(1);
        ready = 1'b0;
    endtask

    task automatic check_zero(string name);
        cmp(name, {row_valid, row_addr, row_bits, lit_count, err_ovf, err_len}, '0);
        cmp(name, row_top | row_bot, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pn;
        int n, hi;
        logic simul;
        pn = ~P;
        step(3);
        check_zero("reset_outputs");
        n_reset = 1'b1;
        step(2);

        send_row(P, 64, 4'h5);
        latch();
        wait_valid();
        cmp("full_top0", row_top[0], P);
        cmp("full_top2", row_top[2], P);
        cmp("full_bot1", row_bot[1], pn);
        cmp("full_addr", row_addr, 5);
        cmp("full_bits", row_bits, 64);
        cmp("full_errs", {err_ovf, err_len}, 0);
        cmp("model_top0", m_top[0], P);
        accept();

        oe = 1'b0;
        step(500);
        oe = 1'b1;
        send_row(~P, 64, 4'h3);
        latch();
        wait_valid();
        cmp("lit_500", lit_count, 500);
        cmp("model_lit", m_lit, 500);
        accept();

        send_row(P, 63, 4'h7);
        rt = {3{P[0]}};
        rb = ~{3{P[0]}};
        bclk = 1'b1;
        le = 1'b1;
        step(2);
        bclk = 1'b0;
        le = 1'b0;
        step(2);
        wait_valid();
        cmp("simul_bits", row_bits, 64);
        cmp("simul_top0", row_top[0], P);
        cmp("simul_len", err_len, 0);
        accept();
        send_row(pn, 64, 4'h8);
        latch();
        wait_valid();
        cmp("restart_bits", row_bits, 64);
        cmp("restart_len", err_len, 0);
        accept();

        send_row(P, 60, 4'h2);
        latch();
        wait_valid();
        cmp("short_bits", row_bits, 60);
        cmp("short_len", err_len, 1);
        accept();

        send_row(P, 64, 4'h1);
        latch();
        send_row(pn, 64, 4'h2);
        latch();
        cmp("bp_valid", row_valid, 1);
        cmp("bp_addr", row_addr, 2);
        cmp("bp_top0", row_top[0], pn);
        cmp("bp_ovf", err_ovf, 1);
        accept();

        n_reset = 1'b0;
        step(1);
        check_zero("reset_clears_errors");
        n_reset = 1'b1;
        step(2);
        send_row(P, 64, 4'h1);
        latch();
        send_row(pn, 64, 4'h2);
        le = 1'b1;
        step(2);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        le = 1'b0;
        step(2);
        cmp("bp_ready_valid", row_valid, 1);
        cmp("bp_ready_addr", row_addr, 2);
        cmp("bp_ready_ovf", err_ovf, 0);
        accept();

        send_row(pn, 30, 4'h6);
        n_reset = 1'b0;
        step(1);
        check_zero("midrow_reset");
        n_reset = 1'b1;
        step(2);
        send_row(P, 64, 4'h9);
        latch();
        wait_valid();
        cmp("midrow_top0", row_top[0], P);
        cmp("midrow_bits", row_bits, 64);
        cmp("midrow_errs", {err_ovf, err_len}, 0);
        accept();

        for (int r = 0; r < 40; r++) begin
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 68)) : 64;
            simul = (n > 0) && ($urandom_range(0, 3) == 0);
            addr = AW'($urandom);
            for (int i = 0; i < n; i++) begin
                oe = 1'($urandom_range(0, 1));
                ready = 1'($urandom_range(0, 1));
                rt = 3'($urandom);
                rb = 3'($urandom);
                bclk = 1'b1;
                if (simul && i == n - 1) le = 1'b1;
                hi = int'($urandom_range(2, 4));
                step(hi);
                bclk = 1'b0;
                le = 1'b0;
                step(int'($urandom_range(2, 4)));
            end
            if (!simul) begin
                ready = 1'($urandom_range(0, 1));
                le = 1'b1;
                step(int'($urandom_range(2, 3)));
                le = 1'b0;
                step(2);
            end
            if ($urandom_range(0, 19) == 0) begin
                n_reset = 1'b0;
                step(1);
                n_reset = 1'b1;
            end
        end
        ready = 1'b1;
        oe = 1'b1;
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
